// File: rtl/fp_pkg.sv
// Shared binary32 constants and types for the pipelined single-precision multiplier.
package fp_pkg;

  localparam int unsigned LATENCY = 5;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned EXPI_W = 10;

  localparam int BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef logic signed [EXPI_W-1:0] exp_t;

  localparam exp_t EXP_MIN = 10'sd1;
  localparam exp_t EXP_OVF = 10'sd255;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_ZERO,
    SP_INF,
    SP_NAN
  } special_e;

endpackage

// File: rtl/fp_mult_if.sv
// Operand/result bundle for the binary32 multiplier; clock and reset stay separate.
interface fp_mult_if;
  logic        clk_en;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  modport master (output clk_en, dataa, datab, input result);
  modport slave  (input clk_en, dataa, datab, output result);
endinterface

// File: rtl/fp_round_pack.sv
// Stages 4 and 5 of fp_mult: round-to-nearest-even, then exception/overflow/underflow pack.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             clk_en,
  input  logic             sign_i,
  input  exp_t             exp_i,
  input  logic [MAN_W-1:0] man_i,
  input  logic             guard_i,
  input  logic             round_i,
  input  logic             sticky_i,
  input  special_e         special_i,
  output logic [31:0]      result_o
);

  logic             s4_sign_d, s4_sign_q;
  exp_t             s4_exp_d, s4_exp_q;
  logic [MAN_W-1:0] s4_man_d, s4_man_q;
  special_e         s4_special_d, s4_special_q;
  logic [31:0]      result_d, result_q;

  logic             inc;
  logic [MAN_W:0]   rsum;

  always_comb begin
    inc          = guard_i & (round_i | sticky_i | man_i[0]);
    rsum         = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
    // A carry out of the fraction leaves it wrapped to zero: exactly the renormalised 1.0 mantissa.
    s4_man_d     = rsum[MAN_W-1:0];
    s4_exp_d     = rsum[MAN_W] ? exp_i + exp_t'(1) : exp_i;
    s4_sign_d    = sign_i;
    s4_special_d = special_i;
  end

  always_comb begin
    result_d = '0;
    unique case (s4_special_q)
      SP_NAN:  result_d = QNAN;
      SP_INF:  result_d = INF | {s4_sign_q, 31'b0};
      SP_ZERO: result_d = {s4_sign_q, 31'b0};
      default: begin
        if (s4_exp_q < EXP_MIN)
          result_d = {s4_sign_q, 31'b0};
        else if (s4_exp_q >= EXP_OVF)
          result_d = INF | {s4_sign_q, 31'b0};
        else
          result_d = {s4_sign_q, s4_exp_q[EXP_W-1:0], s4_man_q};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s4_sign_q    <= 1'b0;
      s4_exp_q     <= '0;
      s4_man_q     <= '0;
      s4_special_q <= SP_NONE;
      result_q     <= '0;
    end else if (clk_en) begin
      s4_sign_q    <= s4_sign_d;
      s4_exp_q     <= s4_exp_d;
      s4_man_q     <= s4_man_d;
      s4_special_q <= s4_special_d;
      result_q     <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/fp_mult.sv
// Five-stage binary32 multiplier: unpack/classify, multiply, normalise, round, pack.
module fp_mult
  import fp_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic             s1_sign_d, s1_sign_q;
  exp_t             s1_exp_d, s1_exp_q;
  logic [SIG_W-1:0] s1_siga_d, s1_siga_q, s1_sigb_d, s1_sigb_q;
  special_e         s1_special_d, s1_special_q;

  logic              s2_sign_d, s2_sign_q;
  exp_t              s2_exp_d, s2_exp_q;
  logic [PROD_W-1:0] s2_prod_d, s2_prod_q;
  special_e          s2_special_d, s2_special_q;

  logic             s3_sign_d, s3_sign_q;
  exp_t             s3_exp_d, s3_exp_q;
  logic [MAN_W-1:0] s3_man_d, s3_man_q;
  logic             s3_guard_d, s3_guard_q;
  logic             s3_round_d, s3_round_q;
  logic             s3_sticky_d, s3_sticky_q;
  special_e         s3_special_d, s3_special_q;

  // Stage 1: denormals are flushed by classifying any zero exponent as zero.
  always_comb begin
    ea     = dataa[30:23];
    eb     = datab[30:23];
    ma     = dataa[22:0];
    mb     = datab[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ALL_ONES) && (ma == '0);
    b_inf  = (eb == EXP_ALL_ONES) && (mb == '0);
    a_nan  = (ea == EXP_ALL_ONES) && (ma != '0);
    b_nan  = (eb == EXP_ALL_ONES) && (mb != '0);

    s1_special_d = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      s1_special_d = SP_NAN;
    else if (a_inf || b_inf)
      s1_special_d = SP_INF;
    else if (a_zero || b_zero)
      s1_special_d = SP_ZERO;

    s1_sign_d = dataa[31] ^ datab[31];
    s1_exp_d  = exp_t'({2'b00, ea}) + exp_t'({2'b00, eb}) - exp_t'(BIAS);
    s1_siga_d = {1'b1, ma};
    s1_sigb_d = {1'b1, mb};
  end

  always_comb begin
    s2_sign_d    = s1_sign_q;
    s2_exp_d     = s1_exp_q;
    s2_special_d = s1_special_q;
    s2_prod_d    = {{SIG_W{1'b0}}, s1_siga_q} * {{SIG_W{1'b0}}, s1_sigb_q};
  end

  // Stage 3: a product in [2,4) is shifted right once; the shifted-out bit joins the sticky.
  always_comb begin
    s3_sign_d    = s2_sign_q;
    s3_special_d = s2_special_q;
    if (s2_prod_q[PROD_W-1]) begin
      s3_exp_d    = s2_exp_q + exp_t'(1);
      s3_man_d    = s2_prod_q[46:24];
      s3_guard_d  = s2_prod_q[23];
      s3_round_d  = s2_prod_q[22];
      s3_sticky_d = |s2_prod_q[21:0];
    end else begin
      s3_exp_d    = s2_exp_q;
      s3_man_d    = s2_prod_q[45:23];
      s3_guard_d  = s2_prod_q[22];
      s3_round_d  = s2_prod_q[21];
      s3_sticky_d = |s2_prod_q[20:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_siga_q    <= '0;
      s1_sigb_q    <= '0;
      s1_special_q <= SP_NONE;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_prod_q    <= '0;
      s2_special_q <= SP_NONE;
      s3_sign_q    <= 1'b0;
      s3_exp_q     <= '0;
      s3_man_q     <= '0;
      s3_guard_q   <= 1'b0;
      s3_round_q   <= 1'b0;
      s3_sticky_q  <= 1'b0;
      s3_special_q <= SP_NONE;
    end else if (clk_en) begin
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_siga_q    <= s1_siga_d;
      s1_sigb_q    <= s1_sigb_d;
      s1_special_q <= s1_special_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_prod_q    <= s2_prod_d;
      s2_special_q <= s2_special_d;
      s3_sign_q    <= s3_sign_d;
      s3_exp_q     <= s3_exp_d;
      s3_man_q     <= s3_man_d;
      s3_guard_q   <= s3_guard_d;
      s3_round_q   <= s3_round_d;
      s3_sticky_q  <= s3_sticky_d;
      s3_special_q <= s3_special_d;
    end
  end

  fp_round_pack u_round_pack (
    .clock     (clock),
    .resetn    (resetn),
    .clk_en    (clk_en),
    .sign_i    (s3_sign_q),
    .exp_i     (s3_exp_q),
    .man_i     (s3_man_q),
    .guard_i   (s3_guard_q),
    .round_i   (s3_round_q),
    .sticky_i  (s3_sticky_q),
    .special_i (s3_special_q),
    .result_o  (result)
  );

endmodule

// File: tb/tb_fp_mult.sv
// Self-checking bench for fp_mult: integer-arithmetic reference model, directed vectors, random stream.
module tb_fp_mult;
  import fp_pkg::*;

  localparam int NV = 15;

  logic clock = 1'b0;
  logic resetn;
  fp_mult_if bus();

  fp_mult dut (
    .clock  (clock),
    .resetn (resetn),
    .clk_en (bus.clk_en),
    .dataa  (bus.dataa),
    .datab  (bus.datab),
    .result (bus.result)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;
  logic [31:0] exp_pipe [LATENCY];

  logic [31:0] va [NV] = '{32'h3FC00000, 32'hBF800000, 32'h3F800001, 32'h7F7FFFFF, 32'h00000001,
                           32'h7F800000, 32'h3F800001, 32'hFF800000, 32'h80000000, 32'h00800000,
                           32'h3F800001, 32'hFF800001, 32'h00800000, 32'h7F000000, 32'h7F000000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h40000000, 32'h3F800000,
                           32'h00000000, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h00800000,
                           32'h3FFFFFFE, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
  logic [31:0] ve [NV] = '{32'h40400000, 32'hBF000000, 32'h3F800002, 32'h7F800000, 32'h00000000,
                           32'h7FC00000, 32'h3FC00002, 32'hFF800000, 32'h80000000, 32'h00000000,
                           32'h40000000, 32'h7FC00000, 32'h00800000, 32'h7F000000, 32'h7F800000};

  // Exact product of the significands, rounded by comparing the discarded remainder against half an ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, msb, sh;
    longint unsigned p, q, rem, half;
    logic s;
    bit an, bn, ai, bi, az, bz;
    ea = 32'(a[30:23]);
    eb = 32'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 23'h0);
    bi = (eb == 255) && (b[22:0] == 23'h0);
    an = (ea == 255) && (a[22:0] != 23'h0);
    bn = (eb == 255) && (b[22:0] != 23'h0);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'h0};
    if (az || bz) return {s, 31'h0};
    p = {40'h0, 1'b1, a[22:0]};
    p = p * {40'h0, 1'b1, b[22:0]};
    msb  = p[47] ? 47 : 46;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ea + eb - 127 + (msb - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e < 1) return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int unsigned k;
    k = $urandom_range(0, 15);
    v = $urandom;
    if (k < 2) begin
      case ($urandom_range(0, 7))
        0: v = 32'h00000000;
        1: v = 32'h80000000;
        2: v = 32'h7F800000;
        3: v = 32'hFF800000;
        4: v = 32'h7FC00000;
        5: v = 32'h7F800001;
        6: v = 32'h00000001;
        default: v = 32'h807FFFFF;
      endcase
    end else if (k < 4) begin
      v = v;
    end else if (k < 6) begin
      v[22:0]  = 23'h7FFFF0 | {19'h0, v[3:0]};
      v[30:23] = 8'($urandom_range(100, 154));
    end else if (k < 9) begin
      v[30:23] = 8'($urandom_range(1, 254));
    end else begin
      v[30:23] = 8'($urandom_range(96, 158));
    end
    return v;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      armed <= 1'b1;
      for (int i = 0; i < LATENCY; i++) exp_pipe[i] <= '0;
    end else if (bus.clk_en) begin
      exp_pipe[0] <= ref_mul(bus.dataa, bus.datab);
      for (int i = 1; i < LATENCY; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      checks++;
      if (bus.result !== exp_pipe[LATENCY-1]) begin
        failures++;
        $display("FAIL model_compare t=%0t: result=%08h expected=%08h", $time, bus.result, exp_pipe[LATENCY-1]);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, expv);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic en);
    bus.dataa  = a;
    bus.datab  = b;
    bus.clk_en = en;
    @(posedge clock);
    #1;
  endtask

  task automatic run_stream(input int fz);
    int nen;
    int idx;
    logic en;
    nen = 0;
    for (int c = 0; c < NV + 9; c++) begin
      en = !(c >= fz && c < fz + 3);
      if (nen < NV) step(va[nen], vb[nen], en);
      else          step(32'h0, 32'h0, en);
      if (en) nen++;
      if (nen >= LATENCY) begin
        idx = nen - LATENCY;
        lit($sformatf("stream%0d_fz%0d", idx, fz), bus.result, (idx < NV) ? ve[idx] : 32'h0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    resetn     = 1'b0;
    bus.clk_en = 1'b1;
    bus.dataa  = '0;
    bus.datab  = '0;

    lit("model_basic", ref_mul(32'h3FC00000, 32'h40000000), 32'h40400000);
    lit("model_tie",   ref_mul(32'h3F800001, 32'h3FC00000), 32'h3FC00002);
    lit("model_carry", ref_mul(32'h3F800001, 32'h3FFFFFFE), 32'h40000000);
    lit("model_nan",   ref_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);

    repeat (2) @(posedge clock);
    #1;
    lit("reset_state", bus.result, 32'h0);
    resetn = 1'b1;

    step(32'h3FC00000, 32'h40000000, 1'b1);
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (bus.result === 32'h40400000) begin
        failures++;
        $display("FAIL early_result: got %08h at enabled edge %0d, required later", bus.result, k);
      end
      step(32'h0, 32'h0, 1'b1);
    end
    lit("latency5", bus.result, 32'h40400000);

    run_stream(1000);
    run_stream(3);
    run_stream(7);

    for (int k = 0; k < 3; k++) step(32'h3FC00000, 32'h40000000, 1'b1);
    resetn = 1'b0;
    step(32'h0, 32'h0, 1'b1);
    lit("reset_flush", bus.result, 32'h0);
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(32'h0, 32'h0, 1'b1);
      lit("no_inflight_leak", bus.result, 32'h0);
    end

    for (int n = 0; n < 4000; n++) begin
      resetn = ($urandom_range(0, 199) != 0);
      step(rand_op(), rand_op(), ($urandom_range(0, 9) != 0));
    end
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) step(32'h0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
